// File: rtl/riscv_v_pkg.sv
// Shared types and constants for the vector datapath.
// Includes the writeback queue entry and the mask-packing FSM states.
package riscv_v_pkg;

  localparam int RISCV_V_NUM_BYTES_DATA = 16;
  localparam int RISCV_V_MASK_WIDTH     = RISCV_V_NUM_BYTES_DATA * 8;

  typedef struct packed {
    logic [RISCV_V_MASK_WIDTH-1:0]     data;
    logic [RISCV_V_NUM_BYTES_DATA-1:0] byte_en;
    logic [RISCV_V_NUM_BYTES_DATA-1:0] cf;
    logic                              is_mask;
  } riscv_v_wb_entry_t;

  typedef enum logic {
    WB_PASS,
    WB_ACCUM
  } riscv_v_wb_state_e;

endpackage

// File: rtl/riscv_v_wb_fifo2.sv
// Two-entry in-order valid/ready queue of writeback entries.
// Ready depends only on occupancy, so there is no combinational path from out_ready_i to in_ready_o.
module riscv_v_wb_fifo2
  import riscv_v_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  riscv_v_wb_entry_t in_entry_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output riscv_v_wb_entry_t out_entry_o
);

  riscv_v_wb_entry_t head_q, head_d;
  riscv_v_wb_entry_t tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              push;
  logic              pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign out_entry_o = head_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_entry_i;
        else                 tail_d = in_entry_i;
      end
      2'b01: head_d = tail_q;
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_entry_i;
        end else begin
          head_d = tail_q;
          tail_d = in_entry_i;
        end
      end
      default: ;
    endcase
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // NOTE: storage is reset too, because the head entry drives out_* directly and must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/riscv_v_adder_wb.sv
// Writeback stage after the vector adder: queues arithmetic beats and packs
// per-element compare bits across beats into one mask word written on the last beat.
module riscv_v_adder_wb
  import riscv_v_pkg::*;
#(
  parameter int DATA_BYTES = RISCV_V_NUM_BYTES_DATA,
  parameter int MASK_WIDTH = DATA_BYTES * 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_BYTES*8-1:0] in_result,
  input  logic [DATA_BYTES-1:0]   in_byte_valid,
  input  logic [DATA_BYTES-1:0]   in_cf,
  input  logic                    in_is_cmp,
  input  logic [1:0]              in_osize,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_BYTES*8-1:0] out_data,
  output logic [DATA_BYTES-1:0]   out_byte_en,
  output logic [DATA_BYTES-1:0]   out_cf,
  output logic                    out_is_mask,
  output logic                    err_overflow,
  output logic                    err_protocol
);

  localparam int BIT_W  = $clog2(MASK_WIDTH);
  localparam int PTR_W  = BIT_W + 1;
  localparam int POS_W  = PTR_W + 1;
  localparam int BYTE_W = $clog2(DATA_BYTES);
  localparam int EPB_W  = BYTE_W + 1;

  riscv_v_wb_state_e       state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [MASK_WIDTH-1:0]   mask_acc_q, mask_acc_d;
  logic                    err_overflow_q, err_overflow_d;
  logic                    err_protocol_q, err_protocol_d;

  logic [EPB_W-1:0]        epb;
  logic [BYTE_W-1:0]       byte_idx;
  logic [POS_W-1:0]        pos;
  logic [POS_W-1:0]        ptr_sum;
  logic [PTR_W-1:0]        ptr_adv;
  logic [MASK_WIDTH-1:0]   merged;
  logic                    drop;
  logic                    accept;
  logic                    push;
  riscv_v_wb_entry_t       push_entry;
  riscv_v_wb_entry_t       head;

  assign accept = in_valid & in_ready;

  // Element e sits at byte e<<osize; its bit is that byte's LSB gated by its byte valid.
  always_comb begin
    epb      = EPB_W'(DATA_BYTES >> in_osize);
    merged   = mask_acc_q;
    drop     = 1'b0;
    byte_idx = '0;
    pos      = '0;
    for (int e = 0; e < DATA_BYTES; e++) begin
      byte_idx = BYTE_W'(e << in_osize);
      pos      = POS_W'(ptr_q) + POS_W'(e);
      if (EPB_W'(e) < epb) begin
        if (pos < POS_W'(MASK_WIDTH)) begin
          merged[pos[BIT_W-1:0]] = in_result[{byte_idx, 3'b000}] & in_byte_valid[byte_idx];
        end else begin
          drop = 1'b1;
        end
      end
    end
    ptr_sum = POS_W'(ptr_q) + POS_W'(epb);
    ptr_adv = (ptr_sum > POS_W'(MASK_WIDTH)) ? PTR_W'(MASK_WIDTH) : ptr_sum[PTR_W-1:0];
  end

  // NOTE: every target gets a default before the branches so this block cannot infer a latch.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    mask_acc_d     = mask_acc_q;
    err_overflow_d = err_overflow_q;
    err_protocol_d = err_protocol_q;
    push           = 1'b0;
    push_entry     = '{data: in_result, byte_en: in_byte_valid, cf: in_cf, is_mask: 1'b0};
    if (accept) begin
      if (in_is_cmp) begin
        if (drop) err_overflow_d = 1'b1;
        if (in_last) begin
          push       = 1'b1;
          push_entry = '{data: merged, byte_en: '1, cf: '0, is_mask: 1'b1};
          state_d    = WB_PASS;
          ptr_d      = '0;
          mask_acc_d = '0;
        end else begin
          state_d    = WB_ACCUM;
          ptr_d      = ptr_adv;
          mask_acc_d = merged;
        end
      end else begin
        push = 1'b1;
        if (state_q == WB_ACCUM) begin
          err_protocol_d = 1'b1;
          state_d        = WB_PASS;
          ptr_d          = '0;
          mask_acc_d     = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WB_PASS;
      ptr_q          <= '0;
      mask_acc_q     <= '0;
      err_overflow_q <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      mask_acc_q     <= mask_acc_d;
      err_overflow_q <= err_overflow_d;
      err_protocol_q <= err_protocol_d;
    end
  end

  riscv_v_wb_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (push),
    .in_ready_o (in_ready),
    .in_entry_i (push_entry),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_entry_o(head)
  );

  assign out_data     = head.data;
  assign out_byte_en  = head.byte_en;
  assign out_cf       = head.cf;
  assign out_is_mask  = head.is_mask;
  assign err_overflow = err_overflow_q;
  assign err_protocol = err_protocol_q;

endmodule
